// File: rtl/spi_clock_divider.sv
// Programmable integer divider producing the SPI serial clock from clk_in,
// with clean enable start/stop and a combinational test bypass.
module spi_clock_divider #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 test_pin,
    input  logic [DIV_WIDTH-1:0] int_div,
    output logic                 clk_out
);

    localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] eff;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt;
    logic                 clk_q;
    logic [DIV_WIDTH-1:0] div_next;
    logic [DIV_WIDTH-1:0] cnt_next;
    logic                 wrap;

    assign eff  = (int_div < MIN_DIV) ? MIN_DIV : int_div;
    assign wrap = (cnt == div_q - ONE);

    // A new divisor is only accepted at the period boundary so a mid-period
    // change can never shorten or stretch the running period.
    always_comb begin
        div_next = div_q;
        cnt_next = cnt + ONE;
        if (wrap) begin
            div_next = eff;
            cnt_next = '0;
        end
    end

    // Idle parks the counter at the last low-phase slot so the first enabled
    // edge wraps to 0 and starts with a full high phase.
    always_ff @(posedge clk_in) begin
        if (rst || !enable) begin
            div_q <= eff;
            cnt   <= eff - ONE;
            clk_q <= 1'b0;
        end else begin
            div_q <= div_next;
            cnt   <= cnt_next;
            clk_q <= (cnt_next < (div_next >> 1));
        end
    end

    assign clk_out = test_pin ? clk_in : clk_q;

endmodule

// File: tb/tb_spi_clock_divider.sv
// Self-checking bench: directed test-plan sequences followed by random
// stimulus, compared cycle by cycle against a waveform-queue reference model.
module tb_spi_clock_divider;

    localparam int DIV_WIDTH = 8;

    logic                 clk_in;
    logic                 rst;
    logic                 enable;
    logic                 test_pin;
    logic [DIV_WIDTH-1:0] int_div;
    logic                 clk_out;

    int n_checks = 0;
    int n_fail   = 0;

    spi_clock_divider #(.DIV_WIDTH(DIV_WIDTH)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .enable   (enable),
        .test_pin (test_pin),
        .int_div  (int_div),
        .clk_out  (clk_out)
    );

    // clock / reset
    initial clk_in = 1'b0;
    always #10 clk_in = ~clk_in;

    // Reference model: each period is pre-expanded into a queue of output
    // levels (floor(N/2) ones, then the rest zeros); every enabled edge
    // consumes one level, and an empty queue means a period boundary.
    logic [0:0] exp_q[$];
    logic       exp_clk = 1'b0;

    always @(posedge clk_in) begin
        int e;
        int h;
        if (rst || !enable) begin
            exp_q.delete();
            exp_clk = 1'b0;
        end else begin
            if (exp_q.size() == 0) begin
                e = (int_div < 2) ? 2 : int'(int_div);
                h = e / 2;
                for (int i = 0; i < e; i++) exp_q.push_back((i < h) ? 1'b1 : 1'b0);
            end
            exp_clk = exp_q.pop_front();
        end
    end

    task automatic check_eq(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, obs, exp);
        end
    endtask

    // One clk_in cycle; inputs change only right after the falling edge.
    task automatic step(input string tag);
        @(posedge clk_in);
        #1;
        if (test_pin) check_eq({tag, "_bypass_hi"}, clk_out, 1'b1);
        @(negedge clk_in);
        if (test_pin) check_eq({tag, "_bypass_lo"}, clk_out, 1'b0);
        else          check_eq(tag, clk_out, exp_clk);
    endtask

    task automatic drive(input logic r, input logic en, input logic tp,
                         input int div, input int cycles, input string tag);
        rst      = r;
        enable   = en;
        test_pin = tp;
        int_div  = DIV_WIDTH'(div);
        for (int i = 0; i < cycles; i++) step(tag);
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        test_pin = 1'b0;
        int_div  = 8'd4;
        @(negedge clk_in);
        drive(1, 0, 0, 4, 3,  "reset");
        drive(0, 0, 0, 4, 25, "idle");
        drive(0, 1, 0, 4, 12, "div4");
        drive(0, 1, 0, 5, 15, "div5");
        drive(0, 1, 0, 0, 8,  "div0");
        drive(0, 1, 0, 1, 8,  "div1");
        drive(0, 1, 0, 4, 5,  "div4_pre_dis");
        drive(0, 0, 0, 4, 10, "disabled");
        drive(0, 1, 0, 4, 8,  "reenable");
        drive(0, 1, 0, 4, 9,  "div4_pre_chg");
        drive(0, 1, 0, 6, 14, "div6");
        drive(0, 0, 1, 6, 5,  "bypass_idle");
        drive(0, 1, 1, 6, 5,  "bypass_run");
        drive(0, 1, 0, 6, 8,  "bypass_exit");
        drive(1, 1, 0, 6, 1,  "mid_reset");
        drive(0, 1, 0, 6, 6,  "post_reset");

        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 15) int_div = DIV_WIDTH'($urandom_range(0, 12));
            else if (r < 17) int_div = DIV_WIDTH'($urandom_range(0, 255));
            r = $urandom_range(0, 99);
            if (r < 4) enable = ~enable;
            rst      = ($urandom_range(0, 199) == 0);
            r = $urandom_range(0, 99);
            if (r < 2) test_pin = ~test_pin;
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
